shared_reg_arbiter: RTL and testbench
=====================================

Name: shared_reg_arbiter

Overview:
Round-robin arbiter and write sequencer for one shared WIDTH-bit D-flip-flop register with true and complement outputs (q/qb).
Up to NREQ requesters compete for write access. The block grants one requester at a time and captures that requester's data into the register.
An optional lock lets the owner perform back-to-back writes, bounded by MAX_HOLD.
The block sits between the requesting clients and the register; the register itself is implemented inside this block.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, register data width
MAX_HOLD, 4, maximum consecutive captures per grant while lock is held (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
req  input  NREQ  per-requester write request, level, held until ack or withdrawn
lock  input  NREQ  per-requester burst lock, sampled only for the current owner
wdata  input  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, registered
ack  output  NREQ  one-cycle capture acknowledge, registered
q  output  WIDTH  shared register value
qb  output  WIDTH  bitwise complement of q, always ~q
busy  output  1  high in GRANT or HOLD
owner  output  clog2(NREQ)  index of current or last owner

Behaviour:
- Reset (rst=0, asynchronous, no clock edge required):
  - q=0, qb=all ones, gnt=0, ack=0, busy=0, owner=0.
  - Internal state: state=IDLE, round-robin pointer ptr=0, hold counter hcnt=0.
  - Reset asserted mid-operation aborts the transfer immediately; no ack is issued.
- Arbitration is round-robin: scan indices ptr, ptr+1, ... modulo NREQ; the first i with req[i]=1 wins.
- States:
  - IDLE: gnt=0.
    - Any req high at an edge -> GRANT; owner=winner; gnt one-hot of winner; hcnt=0.
    - Otherwise stay in IDLE.
  - GRANT: gnt[owner]=1. At the next edge:
    - req[owner]=0 (withdrawn): no capture, no ack; -> IDLE; ptr=owner+1.
    - Else capture: q<=wdata[owner], qb<=~wdata[owner]; ack[owner]=1 for the following cycle; hcnt=1.
      - lock[owner]=1 and hcnt<MAX_HOLD -> HOLD.
      - Otherwise -> IDLE; ptr=owner+1 mod NREQ.
  - HOLD: gnt[owner] stays high. At each edge:
    - req[owner]=1: capture and ack as in GRANT; hcnt++.
    - Leave to IDLE (ptr=owner+1) when lock[owner]=0, req[owner]=0, or hcnt reaches MAX_HOLD (forced release even with lock high).
    - A withdrawn request captures nothing.
- Latency: request sampled at edge E -> gnt visible after E -> q updated at E+1 -> ack visible after E+1 for exactly one cycle.
- Throughput: one IDLE cycle between grants; unlocked single writes take 2 cycles each.
- Requests arriving during GRANT/HOLD wait; they are not lost while held high.
- ptr wraps from NREQ-1 to 0.
- Both captures and releases advance ptr, so no requester starves.
- At most one gnt bit and at most one ack bit is high in any cycle.
- lock of a non-owner is ignored.
- q holds its value in all cycles without a capture.
- qb equals ~q at all times, including during and after reset.

Test Plan:
- Reset: drive rst=0 with clk stopped -> q=8'h00, qb=8'hFF, gnt=4'b0000, busy=0 immediately; release rst -> state unchanged until req.
- Single write: req=4'b0100, slice2=8'hA5 -> gnt=4'b0100 one cycle later; q=8'hA5, qb=8'h5A one edge after that; ack=4'b0100 for exactly one cycle; then IDLE.
- Fairness: req=4'b1111 held, lock=0, distinct data 8'h10/8'h21/8'h32/8'h43 -> grants in order 0,1,2,3,0; each capture 2 cycles apart; q follows the same sequence.
- Bounded lock:
  - req[1]=lock[1]=1, slice1 changing 11,22,33,44,55 each cycle, req[3]=1 pending.
  - Expected: exactly 4 captures (q=11,22,33,44), 4 ack[1] pulses, forced release, then grant goes to requester 3.
  - 55 is never captured.
- Abort: req[0] asserted, then dropped during GRANT -> no ack, q keeps its prior value 8'hA5, return to IDLE, ptr=1.
- Async reset mid-HOLD: assert rst=0 between clock edges while owner=2 holds -> gnt, ack, busy=0 and q=8'h00 without a clock edge; no ack issued afterwards.

Source files
------------

// File: rtl/shared_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : shared_reg_arbiter_if
// Brief   : client-side bus of the shared register arbiter
// Rev     : 1.0
// ============================================================================
interface shared_reg_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int c_ow = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qb;
  logic                  busy;
  logic [c_ow-1:0]       owner;

  modport master (
    output req, lock, wdata,
    input  gnt, ack, q, qb, busy, owner
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, ack, q, qb, busy, owner
  );
endinterface
`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : shared_reg_arbiter
// Brief   : round-robin write arbiter with bounded lock for a shared q/qb reg
// Rev     : 1.0
// ============================================================================
module shared_reg_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  shared_reg_arbiter_if.slave bus
);

  localparam int c_ow = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_hw = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_ow-1:0]   r_ptr;
  logic [c_ow-1:0]   r_owner;
  logic [c_hw-1:0]   r_hcnt;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_ack;
  logic [WIDTH-1:0]  r_q;

  state_t            w_state;
  logic [c_ow-1:0]   w_ptr;
  logic [c_ow-1:0]   w_owner;
  logic [c_hw-1:0]   w_hcnt;
  logic [NREQ-1:0]   w_gnt;
  logic [NREQ-1:0]   w_ack;
  logic [WIDTH-1:0]  w_q;

  logic              w_found;
  logic [c_ow-1:0]   w_winner;
  logic [c_ow:0]     w_scan;
  logic [NREQ-1:0]   w_winner_oh;
  logic [NREQ-1:0]   w_owner_oh;
  logic              w_own_req;
  logic              w_own_lock;
  logic [WIDTH-1:0]  w_own_data;
  logic [c_ow-1:0]   w_ptr_next;
  logic [c_hw-1:0]   w_hcnt_inc;

  // Round-robin scan starting at r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_scan   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = {1'b0, r_ptr} + (c_ow + 1)'(k);
      if (w_scan >= (c_ow + 1)'(NREQ)) begin
        w_scan = w_scan - (c_ow + 1)'(NREQ);
      end
      if (!w_found && bus.req[w_scan[c_ow-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_scan[c_ow-1:0];
      end
    end
  end

  always_comb begin
    w_winner_oh = '0;
    w_owner_oh  = '0;
    w_own_req   = 1'b0;
    w_own_lock  = 1'b0;
    w_own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_winner_oh[i] = (w_winner == c_ow'(i));
      w_owner_oh[i]  = (r_owner == c_ow'(i));
      if (r_owner == c_ow'(i)) begin
        w_own_req  = bus.req[i];
        w_own_lock = bus.lock[i];
        w_own_data = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_next = (r_owner == c_ow'(NREQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_hcnt_inc = r_hcnt + 1'b1;

  // GRANT and HOLD share one rule set: GRANT always enters with hcnt=0.
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_owner = r_owner;
    w_hcnt  = r_hcnt;
    w_gnt   = r_gnt;
    w_ack   = '0;
    w_q     = r_q;
    case (r_state)
      S_IDLE: begin
        w_gnt = '0;
        if (w_found) begin
          w_state = S_GRANT;
          w_owner = w_winner;
          w_gnt   = w_winner_oh;
          w_hcnt  = '0;
        end
      end
      S_GRANT, S_HOLD: begin
        if (!w_own_req) begin
          w_state = S_IDLE;
          w_gnt   = '0;
          w_ptr   = w_ptr_next;
        end else begin
          w_q    = w_own_data;
          w_ack  = w_owner_oh;
          w_hcnt = w_hcnt_inc;
          if (w_own_lock && (w_hcnt_inc < c_hw'(MAX_HOLD))) begin
            w_state = S_HOLD;
          end else begin
            w_state = S_IDLE;
            w_gnt   = '0;
            w_ptr   = w_ptr_next;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_gnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_hcnt  <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_q     <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_owner <= w_owner;
      r_hcnt  <= w_hcnt;
      r_gnt   <= w_gnt;
      r_ack   <= w_ack;
      r_q     <= w_q;
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.ack   = r_ack;
  assign bus.q     = r_q;
  assign bus.qb    = ~r_q;
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.owner = r_owner;

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(r_gnt));
  a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(r_ack));
  a_ack_owner:   assert property (@(posedge clk) disable iff (!rst)
                                  (r_ack == '0) || r_ack[r_owner]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_shared_reg_arbiter
// Brief   : directed + random bench against a behavioural arbiter model
// Rev     : 1.0
// ============================================================================
module tb_shared_reg_arbiter;
  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic clk_en = 1'b0;

  always #5 if (clk_en) clk = ~clk;

  shared_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  shared_reg_arbiter #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model: who owns the register, how many writes it has made.
  int         m_busy, m_owner, m_ptr, m_hcnt, m_ack;
  logic [7:0] m_q;
  int         n_checks, n_fail, cyc, ack1_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_hcnt = 0; m_ack = -1; m_q = 8'h00;
  endtask

  task automatic model_step();
    m_ack = -1;
    if (m_busy == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_busy == 0 && bus.req[(m_ptr + k) % NREQ]) begin
          m_busy  = 1;
          m_owner = (m_ptr + k) % NREQ;
          m_hcnt  = 0;
        end
      end
    end else if (!bus.req[m_owner]) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % NREQ;
    end else begin
      m_q    = bus.wdata[m_owner*WIDTH +: WIDTH];
      m_ack  = m_owner;
      m_hcnt = m_hcnt + 1;
      if (!bus.lock[m_owner] || m_hcnt >= MAX_HOLD) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % NREQ;
      end
    end
  endtask

  task automatic compare_all();
    logic [NREQ-1:0]  eg, ea;
    logic [WIDTH-1:0] eqb;
    eg = '0; ea = '0;
    if (m_busy != 0) eg[m_owner] = 1'b1;
    if (m_ack >= 0)  ea[m_ack]   = 1'b1;
    eqb = ~m_q;
    check("gnt",   bus.gnt,   eg);
    check("ack",   bus.ack,   ea);
    check("q",     bus.q,     m_q);
    check("qb",    bus.qb,    eqb);
    check("busy",  bus.busy,  m_busy);
    check("owner", bus.owner, m_owner);
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step();
    cyc++;
    @(negedge clk);
    compare_all();
    if (bus.ack[1]) ack1_cnt++;
  endtask

  task automatic set_slice(input int i, input logic [7:0] v);
    bus.wdata[i*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fair_q [5];
    int         fair_o [5];
    logic [7:0] lock_v [4];
    logic [3:0] flip;

    fair_q = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    fair_o = '{0, 1, 2, 3, 0};
    lock_v = '{8'h11, 8'h22, 8'h33, 8'h44};
    n_checks = 0; n_fail = 0; cyc = 0; ack1_cnt = 0;
    model_reset();
    bus.req = '0; bus.lock = '0; bus.wdata = '0;

    // Reset with the clock stopped
    #2 rst = 1'b0;
    #1;
    check("rst_q",    bus.q,    8'h00);
    check("rst_qb",   bus.qb,   8'hFF);
    check("rst_gnt",  bus.gnt,  4'b0000);
    check("rst_ack",  bus.ack,  4'b0000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_own",  bus.owner, 0);
    clk_en = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // Fairness: everyone requests, no locks
    bus.wdata = {8'h43, 8'h32, 8'h21, 8'h10};
    bus.req   = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("fair_gnt", bus.gnt, 1 << fair_o[n]);
      tick();
      check("fair_q",   bus.q,   fair_q[n]);
      check("fair_ack", bus.ack, 1 << fair_o[n]);
    end
    bus.req = '0;
    tick();

    // Single write from requester 2
    bus.wdata = $urandom();
    set_slice(2, 8'hA5);
    bus.req = 4'b0100;
    tick();
    check("sw_gnt",  bus.gnt,  4'b0100);
    check("sw_ack0", bus.ack,  4'b0000);
    check("sw_busy", bus.busy, 1'b1);
    tick();
    check("sw_q",    bus.q,    8'hA5);
    check("sw_qb",   bus.qb,   8'h5A);
    check("sw_ack",  bus.ack,  4'b0100);
    check("model_q", m_q,      8'hA5);
    bus.req = '0;
    tick();
    check("sw_ack1", bus.ack,  4'b0000);
    check("sw_idle", bus.busy, 1'b0);

    // Abort: requester 0 withdraws while granted
    bus.req = 4'b0001;
    tick();
    check("ab_gnt", bus.gnt, 4'b0001);
    bus.req = '0;
    tick();
    check("ab_ack",  bus.ack,  4'b0000);
    check("ab_q",    bus.q,    8'hA5);
    check("ab_busy", bus.busy, 1'b0);
    bus.req = 4'b0011;
    tick();
    check("ab_ptr", bus.gnt, 4'b0010);
    bus.req = '0;
    tick();

    // Bounded lock by requester 1 with requester 3 waiting
    set_slice(1, lock_v[0]);
    set_slice(3, 8'h77);
    bus.req  = 4'b0010;
    bus.lock = 4'b0010;
    tick();
    check("lk_gnt", bus.gnt, 4'b0010);
    bus.req  = 4'b1010;
    ack1_cnt = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("lk_q",   bus.q,   lock_v[n]);
      check("lk_ack", bus.ack, 4'b0010);
      set_slice(1, (n < 3) ? lock_v[n+1] : 8'h55);
    end
    check("lk_rel", bus.busy, 1'b0);
    tick();
    check("lk_gnt3", bus.gnt, 4'b1000);
    bus.req  = 4'b1000;
    bus.lock = '0;
    tick();
    check("lk_q3",   bus.q,    8'h77);
    check("lk_acks", ack1_cnt, 4);
    bus.req = '0;
    tick();

    // Asynchronous reset while requester 2 holds
    set_slice(2, 8'h9C);
    bus.req  = 4'b0100;
    bus.lock = 4'b0100;
    tick();
    tick();
    set_slice(2, 8'h3E);
    tick();
    check("ar_hold", bus.gnt, 4'b0100);
    check("ar_q0",   bus.q,   8'h3E);
    #2 rst = 1'b0;
    #1;
    check("ar_gnt",  bus.gnt,  4'b0000);
    check("ar_ack",  bus.ack,  4'b0000);
    check("ar_busy", bus.busy, 1'b0);
    check("ar_q",    bus.q,    8'h00);
    check("ar_qb",   bus.qb,   8'hFF);
    model_reset();
    tick();
    tick();
    bus.req  = '0;
    bus.lock = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("ar_noack", bus.ack, 4'b0000);

    // Random traffic with occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      flip      = 4'($urandom & $urandom & $urandom);
      bus.req   = bus.req ^ flip;
      bus.lock  = 4'($urandom);
      bus.wdata = $urandom();
      if (!rst) begin
        rst = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
